// File: rtl/knn_pkg.sv
// knn_pkg: shared state encoding, width helpers and distance constant for the kNN classifier
package knn_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_VOTE, S_DECIDE, S_DONE} state_t;
  localparam logic [63:0] DIST_ONES = '1;
  function automatic int dw_of(input int w, input int d);
    return w + $clog2(d);
  endfunction
  function automatic int tw_of(input int c);
    return c > 2 ? $clog2(c) : 1;
  endfunction
endpackage

// File: rtl/knn_topk_insert.sv
// knn_topk_insert: K-entry list kept sorted by ascending distance, one stable insertion per cycle
module knn_topk_insert
  import knn_pkg::*;
#(
  parameter int K  = 7,
  parameter int DW = 35,
  parameter int TW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            ins_valid,
  input  logic [DW-1:0]   ins_dist,
  input  logic [TW-1:0]   ins_type,
  output logic [K*DW-1:0] list_dist,
  output logic [K*TW-1:0] list_type,
  output logic [K-1:0]    list_valid
);
  logic [K:0]      le;
  logic [K*DW-1:0] sd;
  logic [K*TW-1:0] st;
  logic [K-1:0]    sv;
  // le[i+1]: entry i stays in place; le[0] pins the insertion point at the head
  always_comb begin
    le[0] = 1'b1;
    for (int i = 0; i < K; i++) le[i+1] = list_valid[i] && list_dist[i*DW +: DW] <= ins_dist;
  end
  assign sd = list_dist << DW;
  assign st = list_type << TW;
  assign sv = list_valid << 1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      list_dist  <= {K{DIST_ONES[DW-1:0]}};
      list_type  <= '0;
      list_valid <= '0;
    end else if (ins_valid) begin
      for (int i = 0; i < K; i++) begin
        if (!le[i+1]) begin
          list_dist[i*DW +: DW] <= le[i] ? ins_dist : sd[i*DW +: DW];
          list_type[i*TW +: TW] <= le[i] ? ins_type : st[i*TW +: TW];
          list_valid[i]         <= le[i] | sv[i];
        end
      end
    end
  end
endmodule

// File: rtl/knn_stream_classifier.sv
// knn_stream_classifier: streaming Manhattan-distance kNN with running top-K list and majority vote
module knn_stream_classifier
  import knn_pkg::*;
#(
  parameter int D = 6,
  parameter int W = 32,
  parameter int K = 7,
  parameter int L = 15,
  parameter int C = 4,
  localparam int DW = dw_of(W, D),
  localparam int TW = tw_of(C)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [D*W-1:0]  query,
  input  logic            train_valid,
  output logic            train_ready,
  input  logic [D*W-1:0]  train_data,
  input  logic [TW-1:0]   train_type,
  output logic            busy,
  output logic            done,
  output logic [TW-1:0]   class_out,
  output logic [K*DW-1:0] knn_dist,
  output logic [K*TW-1:0] knn_type
);
  localparam int NW = $clog2(L + 1);
  localparam int VW = tw_of(K);
  localparam int CW = $clog2(K + 1);
  if (K < 1 || K > L) begin : g_bad_k
    $error("knn_stream_classifier: K must satisfy 1 <= K <= L");
  end
  state_t          state, nstate;
  logic [D*W-1:0]  q;
  logic [NW-1:0]   n;
  logic [VW-1:0]   vi;
  logic [CW-1:0]   cnt [C];
  logic            acc, go, ins_v;
  logic [DW-1:0]   sum, ins_d;
  logic [TW-1:0]   ins_t, vt, best;
  logic [CW-1:0]   bc;
  logic [K*DW-1:0] ld;
  logic [K*TW-1:0] lt;
  logic [K-1:0]    lv;
  function automatic logic [W-1:0] absd(input logic [W-1:0] a, input logic [W-1:0] b);
    return a > b ? a - b : b - a;
  endfunction
  assign train_ready = state == S_LOAD;
  assign busy        = state != S_IDLE;
  assign done        = state == S_DONE;
  assign acc         = train_valid && train_ready;
  assign go          = state == S_IDLE && start;
  assign vt          = lt[vi*TW +: TW];
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   nstate = start ? S_LOAD : S_IDLE;
      S_LOAD:   nstate = acc && n == NW'(L - 1) ? S_FLUSH : S_LOAD;
      S_FLUSH:  nstate = S_VOTE;
      S_VOTE:   nstate = vi == VW'(K - 1) ? S_DECIDE : S_VOTE;
      S_DECIDE: nstate = S_DONE;
      default:  nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) state <= rst ? S_IDLE : nstate;
  always_comb begin
    sum = '0;
    for (int i = 0; i < D; i++) sum = sum + DW'(absd(q[i*W +: W], train_data[i*W +: W]));
  end
  // lowest class index wins ties because only a strictly larger count replaces it
  always_comb begin
    best = '0;
    bc   = cnt[0];
    for (int c = 1; c < C; c++) begin
      if (cnt[c] > bc) begin
        bc   = cnt[c];
        best = TW'(c);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= '0;
      n         <= '0;
      vi        <= '0;
      ins_v     <= 1'b0;
      ins_d     <= '0;
      ins_t     <= '0;
      class_out <= '0;
      knn_dist  <= {K{DIST_ONES[DW-1:0]}};
      knn_type  <= '0;
      for (int c = 0; c < C; c++) cnt[c] <= '0;
    end else begin
      ins_v <= acc;
      if (acc) begin
        ins_d <= sum;
        ins_t <= train_type;
        n     <= n + 1'b1;
      end
      if (go) begin
        q  <= query;
        n  <= '0;
        vi <= '0;
        for (int c = 0; c < C; c++) cnt[c] <= '0;
      end
      // types outside 0..C-1 match no counter and so cast no vote
      if (state == S_VOTE) begin
        vi <= vi + 1'b1;
        for (int c = 0; c < C; c++) if (lv[vi] && vt == TW'(c)) cnt[c] <= cnt[c] + 1'b1;
      end
      if (state == S_DECIDE) begin
        class_out <= best;
        knn_dist  <= ld;
        knn_type  <= lt;
      end
    end
  end
  knn_topk_insert #(.K(K), .DW(DW), .TW(TW)) u_list (
    .clk(clk), .rst(rst), .clear(go), .ins_valid(ins_v), .ins_dist(ins_d), .ins_type(ins_t),
    .list_dist(ld), .list_type(lt), .list_valid(lv)
  );
endmodule

// File: tb/tb_knn_stream_classifier.sv
// tb_knn_stream_classifier: directed table-driven checks of a C=4 and a C=3 build fed the same stream
module tb_knn_stream_classifier;
  localparam int D = 2, W = 8, K = 3, L = 5, DW = 9, TW = 2;
  localparam logic [K*DW-1:0] ONES = '1;
  logic clk = 0, rst = 1, start = 0, train_valid = 0;
  logic [D*W-1:0] query = '0, train_data = '0;
  logic [TW-1:0] train_type = '0;
  logic ready4, busy4, done4, ready3, busy3, done3;
  logic [TW-1:0] cls4, cls3;
  logic [K*DW-1:0] kd4, kd3;
  logic [K*TW-1:0] kt4, kt3;
  int cyc = 0, pass_n = 0, total = 0;
  typedef struct packed {
    logic [4:0][7:0] x;
    logic [4:0][7:0] y;
    logic [4:0][1:0] t;
    logic [2:0][8:0] ed;
    logic [2:0][1:0] et;
    logic [1:0] ec;
    bit gap;
    bit restart;
    bit inst;
  } case_t;
  case_t tc [5];
  knn_stream_classifier #(.D(D), .W(W), .K(K), .L(L), .C(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .query(query), .train_valid(train_valid),
    .train_ready(ready4), .train_data(train_data), .train_type(train_type), .busy(busy4),
    .done(done4), .class_out(cls4), .knn_dist(kd4), .knn_type(kt4));
  knn_stream_classifier #(.D(D), .W(W), .K(K), .L(L), .C(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .query(query), .train_valid(train_valid),
    .train_ready(ready3), .train_data(train_data), .train_type(train_type), .busy(busy3),
    .done(done3), .class_out(cls3), .knn_dist(kd3), .knn_type(kt3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_n++;
  endtask
  task automatic run_case(input int i);
    int k, last, dc;
    bit tg;
    logic [K*DW-1:0] kd;
    logic [K*TW-1:0] kt;
    logic [TW-1:0] cl;
    @(negedge clk);
    query = 16'h0a0a;
    start = 1;
    train_valid = 1;
    train_data = {tc[i].y[0], tc[i].x[0]};
    train_type = tc[i].t[0];
    @(negedge clk);
    start = 0;
    k = 0;
    tg = 0;
    last = 0;
    for (int n = 0; n < 40 && k < 5; n++) begin
      train_valid = !(tc[i].gap && tg);
      train_data = {tc[i].y[k], tc[i].x[k]};
      train_type = tc[i].t[k];
      if (train_valid && ready4) begin
        k++;
        last = cyc;
      end
      tg = !tg;
      @(negedge clk);
    end
    chk($sformatf("c%0d_accepted", i), k, 5);
    train_valid = 1;
    train_data = 16'h0a0a;
    train_type = 0;
    chk($sformatf("c%0d_ready_drop", i), {31'd0, ready4}, 0);
    dc = -1000;
    for (int n = 0; n < 20; n++) begin
      if (done4) begin
        dc = cyc;
        break;
      end
      start = tc[i].restart && cyc == last + 3;
      @(negedge clk);
    end
    start = 0;
    train_valid = 0;
    chk($sformatf("c%0d_latency", i), dc - last, 6);
    kd = tc[i].inst ? kd3 : kd4;
    kt = tc[i].inst ? kt3 : kt4;
    cl = tc[i].inst ? cls3 : cls4;
    for (int e = 0; e < K; e++) begin
      chk($sformatf("c%0d_dist%0d", i, e), kd[e*DW +: DW], tc[i].ed[e]);
      chk($sformatf("c%0d_type%0d", i, e), kt[e*TW +: TW], tc[i].et[e]);
    end
    chk($sformatf("c%0d_class", i), cl, tc[i].ec);
    @(negedge clk);
    chk($sformatf("c%0d_done_pulse", i), {31'd0, done4}, 0);
    chk($sformatf("c%0d_idle_after", i), {31'd0, busy4}, 0);
  endtask
  initial begin
    int seen;
    // packed element [0] sits rightmost in each concatenation
    tc[0] = '{x: {8'd30, 8'd10, 8'd11, 8'd0, 8'd10}, y: {8'd30, 8'd7, 8'd10, 8'd0, 8'd12},
              t: {2'd2, 2'd3, 2'd1, 2'd2, 2'd1}, ed: {9'd3, 9'd2, 9'd1}, et: {2'd3, 2'd1, 2'd1},
              ec: 2'd1, gap: 0, restart: 0, inst: 0};
    tc[1] = '{x: {8'd10, 8'd19, 8'd5, 8'd10, 8'd15}, y: {8'd3, 8'd10, 8'd10, 8'd15, 8'd10},
              t: {2'd0, 2'd0, 2'd3, 2'd3, 2'd2}, ed: {9'd5, 9'd5, 9'd5}, et: {2'd3, 2'd3, 2'd2},
              ec: 2'd3, gap: 0, restart: 0, inst: 0};
    tc[2] = '{x: {8'd12, 8'd11, 8'd0, 8'd13, 8'd20}, y: {8'd10, 8'd10, 8'd10, 8'd10, 8'd10},
              t: {2'd1, 2'd2, 2'd2, 2'd0, 2'd1}, ed: {9'd3, 9'd2, 9'd1}, et: {2'd0, 2'd1, 2'd2},
              ec: 2'd0, gap: 0, restart: 0, inst: 0};
    tc[3] = tc[0];
    tc[3].gap = 1;
    tc[3].restart = 1;
    tc[4] = '{x: {8'd12, 8'd13, 8'd0, 8'd11, 8'd30}, y: {8'd10, 8'd10, 8'd0, 8'd10, 8'd30},
              t: {2'd2, 2'd1, 2'd0, 2'd3, 2'd0}, ed: {9'd3, 9'd2, 9'd1}, et: {2'd1, 2'd2, 2'd3},
              ec: 2'd1, gap: 0, restart: 0, inst: 1};
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready4}, 0);
    chk("rst_busy", {31'd0, busy4}, 0);
    chk("rst_done", {31'd0, done4}, 0);
    chk("rst_class", cls4, 0);
    chk("rst_dist", kd4, ONES);
    chk("rst_type", kt4, 0);
    for (int i = 0; i < 5; i++) run_case(i);
    @(negedge clk);
    query = 16'h0a0a;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 2; k++) begin
      train_valid = 1;
      train_data = {tc[0].y[k], tc[0].x[k]};
      train_type = tc[0].t[k];
      @(negedge clk);
    end
    rst = 1;
    #1;
    chk("midrst_ready", {31'd0, ready4}, 0);
    chk("midrst_busy", {31'd0, busy4}, 0);
    chk("midrst_dist", kd4, ONES);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (done4 || ready4) seen++;
      @(negedge clk);
    end
    train_valid = 0;
    chk("midrst_quiet", seen, 0);
    run_case(0);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule

// File: doc/knn_stream_classifier.md
# knn_stream_classifier

Streaming k-nearest-neighbour classifier: latches one query vector, accepts L training samples one per cycle over a valid/ready handshake, and computes the Manhattan distance of each sample to the query. It keeps a running top-K list sorted by ascending distance, then takes a majority vote over the K neighbour types and reports the winning class. It sits between the training-sample memory reader and the result writer, and adds streaming input, on-the-fly sorting and classification.

## Interface
Parameters:
- D, 6: features per vector.
- W, 32: unsigned feature width.
- K, 7: neighbours kept; elaboration error unless 1 ≤ K ≤ L.
- L, 15: training samples per classification.
- C, 4: number of classes; TW = max(1, clog2(C)).
- Derived: DW = W + clog2(D), the distance width (no overflow possible).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin classification; honoured only in IDLE.
- query  in  D*W  query vector, feature i at bits [i*W +: W]; sampled on the cycle start is accepted.
- train_valid  in  1  training sample present.
- train_ready  out  1  block accepts a sample.
- train_data  in  D*W  training vector, same packing as query.
- train_type  in  TW  class of the training sample.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle result pulse.
- class_out  out  TW  winning class.
- knn_dist  out  K*DW  sorted distances; entry 0 (nearest) at the LSBs.
- knn_type  out  K*TW  types aligned with knn_dist.

## Operation
- Reset values: train_ready=0, busy=0, done=0, class_out=0, knn_dist all ones, knn_type all zeros. FSM goes to IDLE.
- Reset mid-operation aborts the classification; no done is issued.
- FSM states: IDLE → LOAD → FLUSH → VOTE → DECIDE → DONE → IDLE.
- IDLE:
  - On start, latch query, set every list entry to dist=all ones, type=0, valid=0, clear the sample counter, and go to LOAD.
- LOAD:
  - train_ready=1. A sample is accepted when train_valid && train_ready.
  - Distance is the sum over i of |q_i − t_i| (unsigned), registered one cycle after acceptance.
  - Once the L-th sample is accepted, train_ready drops in the same cycle's next state and the FSM goes to FLUSH.
  - Gaps in train_valid stall LOAD indefinitely.
- Insertion (cycle after acceptance):
  - New entry position = count of valid entries with dist ≤ d. This is stable: equal distances keep arrival order.
  - Entries at and below the position shift down one place; the last entry is dropped.
  - If the list is full and d ≥ entry[K−1], the sample is discarded.
- FLUSH: one cycle so the final insertion completes.
- VOTE: K cycles, one list entry per cycle.
  - Increment count[type] for valid entries whose type < C.
  - Types ≥ C are sorted normally but cast no vote.
- DECIDE: argmax over the C counts; on a tie, the lowest class index wins. Register class_out and copy the list to knn_dist/knn_type.
- DONE: done=1 for one cycle, then IDLE.
- Outputs hold until the next DECIDE or reset.
- start is ignored while busy, including in the DONE cycle. start with train_valid=1 in the same cycle: no sample is accepted that cycle.

## Timing
- Query is accepted at edge s; train_ready=1 from cycle s+1.
- Last sample is accepted in cycle a; the FSM is in FLUSH at a+1, VOTE at a+2..a+K+1, DECIDE at a+K+2.
- done=1 in cycle a+K+3, with class_out/knn_* already valid in that cycle.
- Minimum start-to-done latency is L+K+3 cycles.
- Throughput: one sample per cycle in LOAD, with no bubble between back-to-back samples.

## Structure
- Shared package knn_pkg holds:
  - the state enum;
  - the DW/TW width functions;
  - the all-ones distance constant.
- Sub-module knn_topk_insert holds the K-entry sorted register list with valid bits.
  - Ports: clear, ins_valid, ins_dist, ins_type, and the flattened list outputs.
- Distance adder tree, FSM, vote counters and argmax live in the top module.

## Test plan
Common settings: D=2, W=8, K=3, L=5, C=4, query (10,10) unless stated.
- Nominal classification.
  - Stimulus: samples (10,12)/t1, (0,0)/t2, (11,10)/t1, (10,7)/t3, (30,30)/t2, back to back.
  - Required: knn_dist=1,2,3; knn_type=1,1,3; class_out=1; done exactly 6 cycles after the last acceptance.
- Stable ordering.
  - Stimulus: three samples at d=5 with types 2,3,3, then d=9/t0, d=7/t0.
  - Required: knn_type=2,3,3; class_out=3.
- Vote tie.
  - Stimulus: nearest three have types 2,1,0 and distances 1,2,3; the rest are farther.
  - Required: class_out=0.
- Backpressure.
  - Stimulus: nominal stream with train_valid toggling 1,0,1,0.
  - Required: identical results; done 6 cycles after the 5th acceptance; no extra acceptances.
- Reset mid-LOAD.
  - Stimulus: rst asserted after 2 samples.
  - Required: train_ready=0, busy=0, done never asserted, knn_dist all ones; a new start then completes normally.
- start while busy, and type ≥ C.
  - Stimulus: a second start in VOTE; a C=3 build fed a type-3 sample at d=1.
  - Required: the second start is ignored. The type-3 entry appears at knn_type[0] but is excluded from the vote.
